// File: rtl/query_scheduler_pkg.sv
// Shared constants for the query scheduler: FSM state encodings and result limits.
package query_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INS    = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  // Largest legal quantile in 16-bit fixed point (1.0).
  localparam int unsigned QUANT_MAX = 65536;

  // Fill bit for the latency reported on a search timeout (replicated to DW bits).
  localparam logic TIMEOUT_FILL = 1'b1;

endpackage

// File: rtl/query_scheduler_sync_fifo.sv
// Single-clock show-ahead FIFO; a push on a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/query_scheduler.sv
// Arbitrates the sketch memories between the insert path and queued quantile queries,
// launching one search at a time and returning its result through a valid/ready port.
//
//   state  | meaning
//   IDLE   | nothing in flight; pick insert grant or pop the next query
//   INS    | insert path owns the sketch memories
//   LAUNCH | operands registered; pulse search_en_o or fail an illegal quantile
//   WAIT   | search running; wait for done or timeout
//   RESULT | result presented until r_ready_i
module query_scheduler
  import query_scheduler_pkg::*;
#(
  parameter int unsigned HW      = 10,
  parameter int unsigned DW      = 64,
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned STARVE  = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          q_valid_i,
  output logic          q_ready_o,
  input  logic [DW-1:0] q_id_i,
  input  logic [DW-1:0] q_quantile_i,
  input  logic          ins_req_i,
  output logic          ins_grant_o,
  output logic          search_en_o,
  output logic [DW-1:0] search_id_o,
  output logic [DW-1:0] search_quantile_o,
  input  logic          search_done_i,
  input  logic [DW-1:0] search_latency_i,
  output logic          r_valid_o,
  input  logic          r_ready_i,
  output logic [DW-1:0] r_id_o,
  output logic [DW-1:0] r_latency_o,
  output logic          r_err_o,
  output logic          busy_o
);

  // HW only sizes the downstream sketch datapath; it is checked here for sanity.
  if (HW < 1 || DW < 17 || QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_params
    $error("query_scheduler: illegal parameter combination");
  end

  localparam int unsigned SW = $clog2(STARVE + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] QMAX = DW'(QUANT_MAX);

  state_t          state;
  state_t          state_nxt;
  logic            pop;
  logic [2*DW-1:0] fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic [SW-1:0]   starve_cnt;
  logic            starved;
  logic [TW-1:0]   timer;
  logic [DW-1:0]   op_id;
  logic [DW-1:0]   op_quantile;
  logic [DW-1:0]   res_latency;
  logic            res_err;
  logic            illegal;
  logic            in_flight;

  sync_fifo #(
    .W     (2 * DW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_valid_i),
    .wdata ({q_quantile_i, q_id_i}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign starved   = (starve_cnt == SW'(STARVE));
  assign illegal   = (op_quantile > QMAX);
  assign in_flight = (state == ST_LAUNCH) || (state == ST_WAIT) || (state == ST_RESULT);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ins_req_i && (fifo_empty || !starved)) begin
          state_nxt = ST_INS;
        end else if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_LAUNCH;
        end
      end
      // Leaving INS always passes through IDLE, giving the grant a low cycle.
      ST_INS:    if (!ins_req_i || starved) state_nxt = ST_IDLE;
      ST_LAUNCH: state_nxt = illegal ? ST_RESULT : ST_WAIT;
      ST_WAIT:   if (search_done_i || timer == '0) state_nxt = ST_RESULT;
      ST_RESULT: if (r_ready_i) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_id       <= '0;
      op_quantile <= '0;
      starve_cnt  <= '0;
      timer       <= '0;
      res_latency <= '0;
      res_err     <= 1'b0;
    end else begin
      if (pop) begin
        op_id       <= fifo_rdata[DW-1:0];
        op_quantile <= fifo_rdata[2*DW-1:DW];
        starve_cnt  <= '0;
      end else if (!fifo_empty && !in_flight && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      // Down-counter: WAIT lasts TIMEOUT cycles before terminal count fires.
      if (state == ST_LAUNCH)                   timer <= TW'(TIMEOUT - 1);
      else if (state == ST_WAIT && timer != '0) timer <= timer - 1'b1;

      if (state == ST_LAUNCH && illegal) begin
        res_err     <= 1'b1;
        res_latency <= '0;
      end else if (state == ST_WAIT) begin
        if (search_done_i) begin
          res_err     <= 1'b0;
          res_latency <= search_latency_i;
        end else if (timer == '0) begin
          res_err     <= 1'b1;
          res_latency <= {DW{TIMEOUT_FILL}};
        end
      end
    end
  end

  assign q_ready_o         = !fifo_full;
  assign ins_grant_o       = (state == ST_INS);
  assign search_en_o       = (state == ST_LAUNCH) && !illegal;
  assign search_id_o       = op_id;
  assign search_quantile_o = op_quantile;
  assign r_valid_o         = (state == ST_RESULT);
  assign r_id_o            = op_id;
  assign r_latency_o       = res_latency;
  assign r_err_o           = res_err;
  assign busy_o            = in_flight;

endmodule
